// File: rtl/cle_serial_wr.sv
// cle_serial_wr: CPU-window write engine that frames bytes and shifts
// them out, scrambled, on the SDWR/SDCLK serial link.
module cle_serial_wr #(
  parameter int unsigned CLK_DIV  = 8,
  parameter logic [7:0]  SYNC_PAT = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SSER,
  input  logic       BA13,
  input  logic       BA12,
  input  logic [3:0] BA_CMD,
  input  logic       BR_W,
  input  logic [7:0] BD,
  output logic       SDWR,
  output logic       SDCLK,
  output logic       BUSY,
  output logic       OVR
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

  localparam logic [3:0] CMD_DATA  = 4'h8;
  localparam logic [3:0] CMD_SEED  = 4'h2;
  localparam logic [3:0] CMD_SYNC  = 4'hA;
  localparam logic [3:0] CMD_ABORT = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          byp_q, byp_d;
  logic [5:0]    s_q, s_d;
  logic [5:0]    seed_q, seed_d;
  logic          ovr_q, ovr_d;

  logic          dec, dec_q, dec_qq;
  logic [3:0]    cmd_q;
  logic [7:0]    bd_q;

  logic          stb, last, free;
  logic          dbit, scr, txb;

  assign dec  = ~SSER & ~BA13 & BA12 & ~BR_W;
  assign stb  = dec_q & ~dec_qq;
  assign last = (cnt_q == CNT_LAST);
  // The final STOP clock counts as free so frames can run back to back.
  assign free = (state_q == IDLE) | ((state_q == STOP) & last);

  // s_q[0] is s1, s_q[5] is s6.
  assign dbit = sh_q[0];
  assign scr  = dbit ^ s_q[0] ^ s_q[3] ^ s_q[5];
  assign txb  = byp_q ? dbit : scr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q  <= 1'b0;
      dec_qq <= 1'b0;
      cmd_q  <= 4'h0;
      bd_q   <= 8'h00;
    end else begin
      dec_q  <= dec;
      dec_qq <= dec_q;
      cmd_q  <= BA_CMD;
      bd_q   <= BD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      byp_q   <= 1'b0;
      s_q     <= 6'b0;
      seed_q  <= 6'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      byp_q   <= byp_d;
      s_q     <= s_d;
      seed_q  <= seed_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    sh_d    = sh_q;
    byp_d   = byp_q;
    s_d     = s_q;
    seed_d  = seed_q;
    ovr_d   = ovr_q;

    if (state_q != IDLE && !last) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: ;
      START: begin
        if (last) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (last) begin
          sh_d  = {1'b0, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (!byp_q) begin
            s_d = {s_q[4:0], scr};
          end
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (last) begin
          state_d = IDLE;
          if (byp_q) begin
            s_d = seed_q;
          end
        end
      end
    endcase

    if (stb) begin
      case (cmd_q)
        CMD_DATA: begin
          if (free) begin
            sh_d    = bd_q;
            byp_d   = 1'b0;
            state_d = START;
            cnt_d   = '0;
          end else begin
            ovr_d = 1'b1;
          end
        end
        CMD_SYNC: begin
          if (free) begin
            sh_d    = SYNC_PAT;
            byp_d   = 1'b1;
            state_d = START;
            cnt_d   = '0;
          end else begin
            ovr_d = 1'b1;
          end
        end
        CMD_SEED: begin
          if (free) begin
            seed_d = bd_q[5:0];
            s_d    = bd_q[5:0];
          end else begin
            ovr_d = 1'b1;
          end
        end
        CMD_ABORT: begin
          state_d = IDLE;
          cnt_d   = '0;
          byp_d   = 1'b0;
          s_d     = seed_q;
          ovr_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    SDWR = 1'b1;
    unique case (state_q)
      IDLE:  SDWR = 1'b1;
      START: SDWR = 1'b0;
      DATA:  SDWR = txb;
      STOP:  SDWR = 1'b1;
    endcase
  end

  assign SDCLK = (state_q == IDLE) | (cnt_q >= CNT_HALF);
  assign BUSY  = (state_q != IDLE);
  assign OVR   = ovr_q;

endmodule

// File: tb/tb_cle_serial_wr.sv
// tb_cle_serial_wr: directed checks of framing, scrambling, overrun,
// abort, decode and back-to-back behaviour of cle_serial_wr.
module tb_cle_serial_wr;

  localparam int CLK_DIV = 8;
  localparam int FLEN    = 10 * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic       SSER;
  logic       BA13;
  logic       BA12;
  logic [3:0] BA_CMD;
  logic       BR_W;
  logic [7:0] BD;
  logic       SDWR;
  logic       SDCLK;
  logic       BUSY;
  logic       OVR;

  int n_tests;
  int n_fail;

  logic [5:0] s_m;
  logic [5:0] seed_m;

  cle_serial_wr #(
    .CLK_DIV (CLK_DIV),
    .SYNC_PAT(8'h7E)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SSER  (SSER),
    .BA13  (BA13),
    .BA12  (BA12),
    .BA_CMD(BA_CMD),
    .BR_W  (BR_W),
    .BD    (BD),
    .SDWR  (SDWR),
    .SDCLK (SDCLK),
    .BUSY  (BUSY),
    .OVR   (OVR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference scrambler: s[1..6], out = d ^ s1 ^ s4 ^ s6, LSB first.
  function automatic logic [7:0] scr_byte(input logic [7:0] d,
                                          input logic [5:0] si,
                                          output logic [5:0] so);
    logic [6:1] s;
    logic [7:0] r;
    logic       o;
    s = si;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      o    = d[i] ^ s[1] ^ s[4] ^ s[6];
      r[i] = o;
      s    = {s[5:1], o};
    end
    so = s;
    return r;
  endfunction

  task automatic bus_idle();
    SSER   = 1'b1;
    BA13   = 1'b0;
    BA12   = 1'b1;
    BR_W   = 1'b1;
    BA_CMD = 4'h0;
    BD     = 8'h00;
  endtask

  // Returns one clock after the first edge that registers the write.
  task automatic bus_write(input logic [3:0] cmd, input logic [7:0] d,
                           input int hold);
    @(posedge clk); #1;
    SSER   = 1'b0;
    BA13   = 1'b0;
    BA12   = 1'b1;
    BR_W   = 1'b0;
    BA_CMD = cmd;
    BD     = d;
    repeat (hold) @(posedge clk);
    #1;
    bus_idle();
  endtask

  // Samples one frame-length window, one clock per step.
  task automatic run_frame(output logic [9:0] bits, output int busy_n,
                           output int bad);
    logic cur;
    bits   = '0;
    busy_n = 0;
    bad    = 0;
    cur    = 1'b1;
    for (int c = 0; c < FLEN; c++) begin
      @(posedge clk); #1;
      if (BUSY === 1'b1) busy_n++;
      if (c % CLK_DIV == 0) begin
        bits[c / CLK_DIV] = SDWR;
        cur = SDWR;
      end else if (SDWR !== cur) begin
        bad++;
      end
      if (SDCLK !== ((c % CLK_DIV) >= CLK_DIV / 2)) bad++;
    end
  endtask

  task automatic do_frame(input string nm, input logic [3:0] cmd,
                          input logic [7:0] d, input logic [7:0] exp);
    logic [9:0] bits;
    int         bn;
    int         bad;
    bus_write(cmd, d, 1);
    run_frame(bits, bn, bad);
    n_tests++;
    if (bits !== {1'b1, exp, 1'b0} || bn != FLEN || bad != 0) begin
      n_fail++;
      $display("FAIL %s: bits=%b busy=%0d shape_err=%0d want bits=%b busy=%0d",
               nm, bits, bn, bad, {1'b1, exp, 1'b0}, FLEN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    #12;
    n_tests++;
    if ({SDWR, SDCLK, BUSY, OVR} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 1100",
               {SDWR, SDCLK, BUSY, OVR});
    end
    @(negedge clk);
    rst_n  = 1'b1;
    s_m    = 6'b0;
    seed_m = 6'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({SDWR, SDCLK, BUSY, OVR} !== 4'b1100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 1100",
               {SDWR, SDCLK, BUSY, OVR});
    end
  endtask

  task automatic test_basic_frame();
    logic [9:0] bits;
    int         bn;
    int         bad;
    logic [7:0] e;
    bus_write(4'h8, 8'h01, 1);
    n_tests++;
    if (BUSY !== 1'b0 || SDWR !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: busy=%b sdwr=%b at dec+1 want 0 1",
               BUSY, SDWR);
    end
    run_frame(bits, bn, bad);
    n_tests++;
    if (bits !== 10'b1_1110_1111_0) begin
      n_fail++;
      $display("FAIL data01_bits: got %b want 1111011110", bits);
    end
    n_tests++;
    if (bn != FLEN || bad != 0) begin
      n_fail++;
      $display("FAIL data01_shape: busy=%0d err=%0d want %0d 0",
               bn, bad, FLEN);
    end
    @(posedge clk); #1;
    n_tests++;
    if (BUSY !== 1'b0 || SDWR !== 1'b1 || SDCLK !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_fall: busy=%b sdwr=%b sdclk=%b want 0 1 1",
               BUSY, SDWR, SDCLK);
    end
    e = scr_byte(8'h01, s_m, s_m);
    e = scr_byte(8'h00, s_m, s_m);
    do_frame("state_persist", 4'h8, 8'h00, e);
  endtask

  task automatic test_sync();
    logic [7:0] e;
    bus_write(4'h2, 8'h00, 1);
    seed_m = 6'b0;
    s_m    = 6'b0;
    do_frame("data00_zero", 4'h8, 8'h00, 8'h00);
    e = scr_byte(8'h01, s_m, s_m);
    do_frame("data01_again", 4'h8, 8'h01, 8'hEF);
    do_frame("sync_raw", 4'hA, 8'h55, 8'h7E);
    s_m = seed_m;
    e = scr_byte(8'h01, s_m, s_m);
    do_frame("after_sync_reseed", 4'h8, 8'h01, 8'hEF);
  endtask

  task automatic test_overrun_abort();
    logic [9:0] bits;
    int         bn;
    int         bad;
    logic [7:0] e;
    bus_write(4'h2, 8'h00, 1);
    seed_m = 6'b0;
    s_m    = 6'b0;
    bus_write(4'h8, 8'h01, 1);
    fork
      run_frame(bits, bn, bad);
      begin
        repeat (20) @(posedge clk);
        bus_write(4'h8, 8'hFF, 1);
        repeat (3) @(posedge clk);
        bus_write(4'h2, 8'h3F, 1);
      end
    join
    n_tests++;
    if (bits !== 10'b1_1110_1111_0 || bad != 0) begin
      n_fail++;
      $display("FAIL ovr_frame_intact: got %b err=%0d want 1111011110",
               bits, bad);
    end
    @(posedge clk); #1;
    n_tests++;
    if (OVR !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b want 1", OVR);
    end
    bus_write(4'h8, 8'h55, 1);
    repeat (30) @(posedge clk);
    bus_write(4'h9, 8'h00, 1);
    n_tests++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: busy=%b want 1", BUSY);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({SDWR, SDCLK, BUSY, OVR} !== 4'b1100) begin
      n_fail++;
      $display("FAIL abort_now: got %b want 1100",
               {SDWR, SDCLK, BUSY, OVR});
    end
    s_m = seed_m;
    e = scr_byte(8'h01, s_m, s_m);
    do_frame("seed_unchanged", 4'h8, 8'h01, 8'hEF);
  endtask

  task automatic test_decode();
    logic [9:0] bits;
    int         bn;
    int         bad;
    int         hi;
    logic [7:0] e;
    e = scr_byte(8'hA5, s_m, s_m);
    @(posedge clk); #1;
    SSER   = 1'b0;
    BR_W   = 1'b0;
    BA_CMD = 4'h8;
    BD     = 8'hA5;
    @(posedge clk); #1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        bus_idle();
      end
      run_frame(bits, bn, bad);
    join
    n_tests++;
    if (bits !== {1'b1, e, 1'b0} || bad != 0) begin
      n_fail++;
      $display("FAIL held_write_frame: got %b want %b", bits,
               {1'b1, e, 1'b0});
    end
    hi = 0;
    for (int c = 0; c < 3 * CLK_DIV; c++) begin
      @(posedge clk); #1;
      if (BUSY === 1'b1) hi++;
    end
    n_tests++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL held_write_single: busy clocks=%0d want 0", hi);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      SSER   = (k == 2);
      BR_W   = (k == 0);
      BA12   = (k != 1);
      BA13   = (k == 3);
      BA_CMD = 4'h8;
      BD     = 8'h01;
      repeat (3) @(posedge clk);
      #1;
      bus_idle();
      hi = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (BUSY === 1'b1) hi++;
      end
      n_tests++;
      if (hi != 0) begin
        n_fail++;
        $display("FAIL no_decode_%0d: busy clocks=%0d want 0", k, hi);
      end
    end
  endtask

  task automatic test_scramble_reset();
    logic [7:0] e;
    bus_write(4'h2, 8'hFF, 1);
    seed_m = 6'h3F;
    s_m    = 6'h3F;
    e = scr_byte(8'h00, s_m, s_m);
    do_frame("seed_ff_data00", 4'h8, 8'h00, 8'hFF);
    n_tests++;
    if (e !== 8'hFF) begin
      n_fail++;
      $display("FAIL model_ff: got %h want ff", e);
    end
    e = scr_byte(8'h5A, s_m, s_m);
    do_frame("seed_ff_data5a", 4'h8, 8'h5A, e);
    bus_write(4'h8, 8'h00, 1);
    repeat (9) @(posedge clk);
    #2;
    n_tests++;
    if (BUSY !== 1'b1 || SDCLK !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b sdclk=%b want 1 0", BUSY, SDCLK);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({SDWR, SDCLK, BUSY} !== 3'b110) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 110", {SDWR, SDCLK, BUSY});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    seed_m = 6'b0;
    s_m    = 6'b0;
    e = scr_byte(8'h01, s_m, s_m);
    do_frame("seed_after_reset", 4'h8, 8'h01, 8'hEF);
  endtask

  task automatic test_back_to_back();
    logic [9:0] b1;
    logic [9:0] b2;
    int         n1;
    int         n2;
    int         x1;
    int         x2;
    int         hi;
    logic [7:0] e1;
    logic [7:0] e2;
    e1 = scr_byte(8'h3C, s_m, s_m);
    e2 = scr_byte(8'hC3, s_m, s_m);
    bus_write(4'h8, 8'h3C, 1);
    fork
      begin
        run_frame(b1, n1, x1);
        run_frame(b2, n2, x2);
      end
      begin
        repeat (FLEN - 2) @(posedge clk);
        bus_write(4'h8, 8'hC3, 1);
      end
    join
    n_tests++;
    if (b1 !== {1'b1, e1, 1'b0} || n1 != FLEN || x1 != 0) begin
      n_fail++;
      $display("FAIL b2b_first: got %b busy=%0d want %b", b1, n1,
               {1'b1, e1, 1'b0});
    end
    n_tests++;
    if (b2 !== {1'b1, e2, 1'b0} || n2 != FLEN || x2 != 0) begin
      n_fail++;
      $display("FAIL b2b_second: got %b busy=%0d err=%0d want %b",
               b2, n2, x2, {1'b1, e2, 1'b0});
    end
    @(posedge clk); #1;
    n_tests++;
    if (OVR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: ovr=%b busy=%b want 0 0", OVR, BUSY);
    end
    bus_write(4'h3, 8'h01, 1);
    hi = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (BUSY === 1'b1 || OVR === 1'b1) hi++;
    end
    n_tests++;
    if (hi != 0) begin
      n_fail++;
      $display("FAIL unknown_cmd: active clocks=%0d want 0", hi);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    s_m     = 6'b0;
    seed_m  = 6'b0;
    test_reset();
    test_basic_frame();
    test_sync();
    test_overrun_abort();
    test_decode();
    test_scramble_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cle_serial_wr.md
Name: cle_serial_wr

Overview:
Write-direction serial engine for the CLE serial window. It decodes CPU write cycles in the window SSER low, BA13=0, BA12=1, BR_W=0, with a command in BA7..BA4. It shifts each data byte out on SDWR/SDCLK, scrambled by the same 6-stage self-synchronising scrambler (taps 1, 4, 6) that the read side descrambles. The block sits beside the read-side logic on the same bus window and drives the serial write line to the peripheral.

Parameters:
CLK_DIV, 8, clocks per serial bit; even, >=2.
SYNC_PAT, 8'h7E, byte sent unscrambled by the SYNC command.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst_n  in  1  asynchronous active-low reset.
SSER  in  1  serial window select, active low.
BA13  in  1  bus address bit 13; must be 0 for decode.
BA12  in  1  bus address bit 12; must be 1 for decode.
BA_CMD  in  4  bus address bits BA7..BA4; command code.
BR_W  in  1  bus read/not-write; 0 = write.
BD  in  8  bus write data.
SDWR  out  1  serial write data; idle high.
SDCLK  out  1  serial bit clock; idle high.
BUSY  out  1  frame in progress.
OVR  out  1  sticky overrun flag.

Behaviour:
- Reset (async, rst_n=0):
  - SDWR=1, SDCLK=1, BUSY=0, OVR=0.
  - Seed register=6'b0, scrambler state s[1..6]=0, FSM=IDLE.
  - Reset mid-frame truncates the frame immediately.
- Decode and strobe:
  - dec = ~SSER & ~BA13 & BA12 & ~BR_W, registered each clk.
  - Strobe = dec rising edge (dec_q & ~dec_qq). A multi-cycle bus write gives exactly one strobe.
  - BA_CMD and BD are captured with dec_q.
- Commands (acted on in the strobe cycle):
  - 4'h8 DATA: if IDLE, load BD and go to START. If busy, ignore and set OVR=1.
  - 4'h2 SEED: if IDLE, seed <= BD[5:0] and s <= BD[5:0]. If busy, ignore and set OVR=1.
  - 4'hA SYNC: if IDLE, load SYNC_PAT with the scramble bypass flag and go to START. If busy, ignore and set OVR=1.
  - 4'h9 ABORT: accepted in any state. FSM=IDLE, SDWR=1, SDCLK=1, BUSY=0, s <= seed, OVR=0.
  - All other codes are ignored with no flag change.
- FSM states IDLE -> START -> DATA (8 bits) -> STOP -> IDLE.
  - Each bit lasts exactly CLK_DIV clocks; a bit counter counts 0..CLK_DIV-1.
  - START bit: SDWR=0. STOP bit: SDWR=1.
  - DATA is sent LSB first.
- SDCLK within each bit (START, DATA and STOP): low for the first CLK_DIV/2 clocks, high for the rest.
  - SDWR changes only at the bit start, coincident with SDCLK falling.
  - The receiver samples on SDCLK rising.
- Timing:
  - BUSY and the START bit (SDWR=0) begin on the edge after the strobe, i.e. 2 clocks after dec first goes true.
  - BUSY falls on the edge ending STOP. Frame length = 10*CLK_DIV clocks.
  - A new DATA strobe in the same cycle BUSY falls is accepted; back-to-back frames have no idle gap.
- Scrambler, per DATA bit d in a scrambled frame:
  - out = d ^ s1 ^ s4 ^ s6; SDWR = out.
  - At bit end, s1 <= out and sk <= s(k-1) for k = 2..6.
  - State persists across frames. It is reloaded only by SEED, ABORT, or the end of a SYNC frame.
- SYNC frame: data bits are sent raw (SDWR = d) and s does not advance. At STOP end, s <= seed.
- OVR is sticky until ABORT or reset. A rejected command never disturbs the frame in flight.

Test Plan:
1. Reset, then seed=0, DATA BD=8'h01, CLK_DIV=8 -> START at dec+2 clocks; data bits 1,1,1,1,0,1,1,1 (0xEF); STOP high; BUSY high for 80 clocks; final s=6'b111011 (s1..s6).
2. Seed=0, DATA 8'h00 -> data bits all 0, s stays 0; then SYNC -> raw bits of 0x7E (0,1,1,1,1,1,1,0); s=seed after the frame.
3. DATA while BUSY (mid-frame), also SEED while busy -> current frame bits unchanged, OVR=1, seed unchanged; ABORT -> OVR=0, SDWR=1, BUSY=0 the next clock.
4. Bus write held for 5 clocks -> exactly one frame; read cycle (BR_W=1) or BA12=0 or SSER=1 -> no strobe, BUSY stays 0.
5. SEED BD=8'hFF, DATA 8'h00 -> bit0 out = 1^1^1 = 1; check that later bits match the scrambler equation; assert rst_n low mid-DATA -> SDWR=1, SDCLK=1, BUSY=0 asynchronously, seed=0.
6. DATA strobe timed so it lands in the cycle BUSY falls -> next START follows STOP with no idle clock; unknown command 4'h3 -> no effect.
